// File: rtl/aes_pkg.sv
// Shared AES definitions for the key expansion logic.
// Holds the AES-128 geometry constants, the initial round constant, the
// GF(2^8) doubling helper used to advance the round constant, and the
// state type for the key schedule controller.
// No ports; imported with "import aes_pkg::*;".
package aes_pkg;

  localparam int NK     = 4;
  localparam int NB     = 4;
  localparam int NR_128 = 10;

  localparam logic [7:0] AES_RCON_INIT = 8'h01;

  // Multiply by x in GF(2^8) modulo the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ks_state_t;

endpackage

// File: rtl/key_schedule_seq_subbyte.sv
// subByte: applies the AES S-box independently to each byte of a 32-bit word.
// Ports:
//   i_word  in  32  input word
//   o_word  out 32  S-box substituted word (byte lanes preserved)
module subByte (
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry b sits at bit offset (255-b)*8, and 255-b is simply ~b for a byte.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    sbox = SBOX[{~b, 3'b000} +: 8];
  endfunction

  assign o_word[31:24] = sbox(i_word[31:24]);
  assign o_word[23:16] = sbox(i_word[23:16]);
  assign o_word[15:8]  = sbox(i_word[15:8]);
  assign o_word[7:0]   = sbox(i_word[7:0]);

endmodule

// File: rtl/key_schedule_seq.sv
// key_schedule_seq: sequential AES-128 key expansion.
// Latches a cipher key on start and hands out round keys 0..NUM_ROUNDS one
// per valid/ready handshake. A single subByte instance serves every step.
// Ports:
//   clk        in   1    clock, rising edge
//   rst        in   1    synchronous active-high reset
//   start      in   1    load key_in and begin (only when not busy)
//   key_in     in   128  cipher key, w0 in bits [127:96]
//   round_key  out  128  current round key
//   round_idx  out  4    index of round_key
//   key_valid  out  1    round_key/round_idx valid
//   key_ready  in   1    consumer accepts on key_valid && key_ready
//   busy       out  1    schedule in progress
//   done       out  1    one-cycle pulse after the last key is accepted
module key_schedule_seq
  import aes_pkg::*;
#(
  parameter int         NUM_ROUNDS = NR_128,
  parameter logic [7:0] RCON_INIT  = AES_RCON_INIT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         key_valid,
  input  logic         key_ready,
  output logic         busy,
  output logic         done
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  ks_state_t    r_state;
  logic [127:0] r_roundKey;
  logic [3:0]   r_roundIdx;
  logic [7:0]   r_rcon;
  logic         r_keyValid;
  logic         r_busy;
  logic         r_done;

  ks_state_t    w_stateNext;
  logic [127:0] w_roundKeyNext;
  logic [3:0]   w_roundIdxNext;
  logic [7:0]   w_rconNext;
  logic         w_keyValidNext;
  logic         w_busyNext;
  logic         w_doneNext;

  logic [31:0]  w_w0, w_w1, w_w2, w_w3;
  logic [31:0]  w_rot, w_sub, w_temp;
  logic [31:0]  w_n0, w_n1, w_n2, w_n3;
  logic [127:0] w_nextKey;
  logic         w_fire;

  // Next round key derived combinationally from the key currently on display.
  assign w_w0 = r_roundKey[127:96];
  assign w_w1 = r_roundKey[95:64];
  assign w_w2 = r_roundKey[63:32];
  assign w_w3 = r_roundKey[31:0];

  assign w_rot = {w_w3[23:0], w_w3[31:24]};

  subByte u_subByte (
    .i_word (w_rot),
    .o_word (w_sub)
  );

  assign w_temp    = w_sub ^ {r_rcon, 24'h000000};
  assign w_n0      = w_w0 ^ w_temp;
  assign w_n1      = w_w1 ^ w_n0;
  assign w_n2      = w_w2 ^ w_n1;
  assign w_n3      = w_w3 ^ w_n2;
  assign w_nextKey = {w_n0, w_n1, w_n2, w_n3};

  assign w_fire = r_keyValid && key_ready;

  // Next-state and next-register logic. Everything holds unless a start is
  // taken in IDLE or a handshake completes in RUN; done always drops back to 0.
  always_comb begin
    w_stateNext    = r_state;
    w_roundKeyNext = r_roundKey;
    w_roundIdxNext = r_roundIdx;
    w_rconNext     = r_rcon;
    w_keyValidNext = r_keyValid;
    w_busyNext     = r_busy;
    w_doneNext     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_roundKeyNext = key_in;
          w_roundIdxNext = 4'd0;
          w_rconNext     = RCON_INIT;
          w_keyValidNext = 1'b1;
          w_busyNext     = 1'b1;
          w_stateNext    = RUN;
        end
      end
      RUN: begin
        if (w_fire) begin
          if (r_roundIdx == LAST_IDX) begin
            w_keyValidNext = 1'b0;
            w_busyNext     = 1'b0;
            w_doneNext     = 1'b1;
            w_stateNext    = IDLE;
          end else begin
            w_roundKeyNext = w_nextKey;
            w_roundIdxNext = r_roundIdx + 4'd1;
            w_rconNext     = xtime(r_rcon);
          end
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // State register; reset wins over any start or handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_roundKey <= '0;
      r_roundIdx <= '0;
      r_rcon     <= RCON_INIT;
      r_keyValid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_roundKey <= w_roundKeyNext;
      r_roundIdx <= w_roundIdxNext;
      r_rcon     <= w_rconNext;
      r_keyValid <= w_keyValidNext;
      r_busy     <= w_busyNext;
      r_done     <= w_doneNext;
    end
  end

  assign round_key = r_roundKey;
  assign round_idx = r_roundIdx;
  assign key_valid = r_keyValid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_key_schedule_seq.sv
// Testbench for key_schedule_seq using FIPS-197 key expansion vectors.
module tb_key_schedule_seq;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic         done;

  int compared;
  int mismatched;

  logic [127:0] gotKeys [0:10];
  logic [3:0]   gotIdx  [0:10];
  int           gotCount;
  int           cycles;
  int           unstable;
  int           doneEarly;
  logic         timedOut;
  logic         doneOk;

  localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_ZERO = 128'h0;

  logic [127:0] expA1 [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  localparam logic [127:0] ZERO_K1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_K10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  key_schedule_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .round_key (round_key),
    .round_idx (round_idx),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .busy      (busy),
    .done      (done)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pulse start for one cycle with the given key; on return key 0 should be visible.
  task automatic applyStimulus(input logic [127:0] key);
    key_in = key;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Drives key_ready (readyPct percent of the time) and records accepted keys
  // from index firstIdx onward. Ends at the negedge after the final handshake.
  task automatic collectKeys(input int readyPct, input int firstIdx);
    int           n;
    logic         prevHeld;
    logic [127:0] prevKey;
    logic [3:0]   prevIdx;
    n         = firstIdx;
    timedOut  = 1'b1;
    doneOk    = 1'b0;
    unstable  = 0;
    doneEarly = 0;
    cycles    = 0;
    prevHeld  = 1'b0;
    prevKey   = '0;
    prevIdx   = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (done === 1'b1) doneEarly++;
      if (prevHeld && (round_key !== prevKey || round_idx !== prevIdx || key_valid !== 1'b1))
        unstable++;
      prevHeld = 1'b0;
      if (key_valid === 1'b1) begin
        if (readyPct >= 100) key_ready = 1'b1;
        else key_ready = (int'($urandom_range(99)) < readyPct);
        if (key_ready) begin
          if (n <= 10) begin
            gotKeys[n] = round_key;
            gotIdx[n]  = round_idx;
          end
          n++;
        end else begin
          prevHeld = 1'b1;
          prevKey  = round_key;
          prevIdx  = round_idx;
        end
      end else begin
        key_ready = 1'b0;
      end
      cycles++;
      @(negedge clk);
      if (n >= 11) begin
        doneOk    = (done === 1'b1) && (key_valid === 1'b0) && (busy === 1'b0);
        timedOut  = 1'b0;
        key_ready = 1'b0;
        gotCount  = n;
        return;
      end
    end
    gotCount  = n;
    key_ready = 1'b0;
  endtask

  // Reset drives every output to zero.
  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    compared++;
    if (round_key !== 128'h0 || round_idx !== 4'd0 || key_valid !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset: key=%h idx=%0d valid=%b busy=%b done=%b, required all zero",
               round_key, round_idx, key_valid, busy, done);
    end
    @(negedge clk);
    compared++;
    if (key_valid !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL idle_hold: valid=%b busy=%b, required 0 0", key_valid, busy);
    end
  endtask

  // Full FIPS-197 A.1 schedule with key_ready held high.
  task automatic test_fips_a1();
    applyStimulus(KEY_A1);
    collectKeys(100, 0);
    compared++;
    if (timedOut !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL a1_timeout: got %0d keys, required 11", gotCount);
    end
    compared++;
    if (cycles !== 11) begin
      mismatched++;
      $display("[TB] FAIL a1_throughput: %0d cycles, required 11", cycles);
    end
    for (int i = 0; i <= 10; i++) begin
      compared++;
      if (gotKeys[i] !== expA1[i] || gotIdx[i] !== 4'(i)) begin
        mismatched++;
        $display("[TB] FAIL a1_key%0d: got %h idx %0d, required %h idx %0d",
                 i, gotKeys[i], gotIdx[i], expA1[i], i);
      end
    end
    compared++;
    if (doneOk !== 1'b1 || doneEarly !== 0) begin
      mismatched++;
      $display("[TB] FAIL a1_done: doneOk=%b early=%0d, required 1 0", doneOk, doneEarly);
    end
    @(negedge clk);
    compared++;
    if (done !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL a1_done_pulse: done=%b one cycle later, required 0", done);
    end
  endtask

  // Same key with random backpressure: same keys in order, outputs held while stalled.
  task automatic test_backpressure();
    applyStimulus(KEY_A1);
    collectKeys(50, 0);
    compared++;
    if (timedOut !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL bp_timeout: got %0d keys, required 11", gotCount);
    end
    for (int i = 0; i <= 10; i++) begin
      compared++;
      if (gotKeys[i] !== expA1[i] || gotIdx[i] !== 4'(i)) begin
        mismatched++;
        $display("[TB] FAIL bp_key%0d: got %h idx %0d, required %h idx %0d",
                 i, gotKeys[i], gotIdx[i], expA1[i], i);
      end
    end
    compared++;
    if (unstable !== 0) begin
      mismatched++;
      $display("[TB] FAIL bp_stable: %0d stalled cycles changed output, required 0", unstable);
    end
    compared++;
    if (doneOk !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL bp_done: doneOk=%b, required 1", doneOk);
    end
  endtask

  // All-zero cipher key.
  task automatic test_zero_key();
    applyStimulus(KEY_ZERO);
    collectKeys(100, 0);
    compared++;
    if (gotKeys[0] !== KEY_ZERO) begin
      mismatched++;
      $display("[TB] FAIL zero_key0: got %h, required %h", gotKeys[0], KEY_ZERO);
    end
    compared++;
    if (gotKeys[1] !== ZERO_K1) begin
      mismatched++;
      $display("[TB] FAIL zero_key1: got %h, required %h", gotKeys[1], ZERO_K1);
    end
    compared++;
    if (gotKeys[10] !== ZERO_K10 || timedOut !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL zero_key10: got %h timeout=%b, required %h", gotKeys[10], timedOut, ZERO_K10);
    end
  endtask

  // A start pulse while busy, carrying a different key, must be ignored.
  task automatic test_start_ignored();
    applyStimulus(KEY_A1);
    key_ready = 1'b0;
    key_in    = KEY_ZERO;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    compared++;
    if (round_key !== KEY_A1 || round_idx !== 4'd0 || busy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL ign_hold: got %h idx %0d busy %b, required %h idx 0 busy 1",
               round_key, round_idx, busy, KEY_A1);
    end
    collectKeys(100, 0);
    for (int i = 0; i <= 10; i++) begin
      compared++;
      if (gotKeys[i] !== expA1[i]) begin
        mismatched++;
        $display("[TB] FAIL ign_key%0d: got %h, required %h", i, gotKeys[i], expA1[i]);
      end
    end
  endtask

  // Reset at round 5 aborts; a fresh start then runs the full schedule.
  task automatic test_reset_midrun();
    logic reached;
    reached = 1'b0;
    applyStimulus(KEY_A1);
    key_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (round_idx === 4'd5 && key_valid === 1'b1) begin
        reached = 1'b1;
        break;
      end
      @(negedge clk);
    end
    compared++;
    if (reached !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL mid_reach: round_idx=%0d, required 5", round_idx);
    end
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    key_ready = 1'b0;
    compared++;
    if (key_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL mid_abort: valid=%b busy=%b done=%b, required 0 0 0", key_valid, busy, done);
    end
    key_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    key_ready = 1'b0;
    compared++;
    if (key_valid !== 1'b0 || done !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL mid_quiet: valid=%b done=%b, required 0 0", key_valid, done);
    end
    applyStimulus(KEY_A1);
    collectKeys(100, 0);
    for (int i = 0; i <= 10; i++) begin
      compared++;
      if (gotKeys[i] !== expA1[i]) begin
        mismatched++;
        $display("[TB] FAIL mid_key%0d: got %h, required %h", i, gotKeys[i], expA1[i]);
      end
    end
  endtask

  // Start asserted in the done cycle is taken; rcon restarts at 01.
  task automatic test_back_to_back();
    applyStimulus(KEY_A1);
    collectKeys(100, 0);
    compared++;
    if (doneOk !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL b2b_done: doneOk=%b, required 1", doneOk);
    end
    applyStimulus(KEY_ZERO);
    compared++;
    if (key_valid !== 1'b1 || round_key !== KEY_ZERO || round_idx !== 4'd0 || busy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL b2b_key0: valid=%b key=%h idx=%0d busy=%b, required 1 %h 0 1",
               key_valid, round_key, round_idx, busy, KEY_ZERO);
    end
    collectKeys(100, 0);
    compared++;
    if (gotKeys[1] !== ZERO_K1) begin
      mismatched++;
      $display("[TB] FAIL b2b_key1: got %h, required %h", gotKeys[1], ZERO_K1);
    end
    compared++;
    if (gotKeys[10] !== ZERO_K10) begin
      mismatched++;
      $display("[TB] FAIL b2b_key10: got %h, required %h", gotKeys[10], ZERO_K10);
    end
  endtask

  // Scenario sequence.
  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    start      = 1'b0;
    key_in     = '0;
    key_ready  = 1'b0;
    @(negedge clk);
    test_reset();
    test_fips_a1();
    test_backpressure();
    test_zero_key();
    test_start_ignored();
    test_reset_midrun();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
